// File: rtl/dmem_pkg.sv
// Shared encodings for the handshaked data memory.
package dmem_pkg;

  // Operation encoding on the op bus.
  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_BSET = 2'b10;
  localparam logic [1:0] OP_BCLR = 2'b11;

  // Access sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAcc,
    StRmw,
    StDone
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Storage array: one synchronous write port, one combinational read port, no reset.
module dmem_array #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  // Synchronous write; contents are left uninitialised.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_hs.sv
// Data memory with req/ack handshake, programmable wait states and atomic bit-set/clear.
module data_mem_hs
  import dmem_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 4,
  parameter int unsigned WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [1:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic          ack,
  output logic          busy,
  output logic [DW-1:0] dout
);

  // First count loaded on acceptance; unused when WAIT is zero.
  localparam logic [3:0] WaitInit = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] dout_q, dout_d;
  logic          cap;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  dmem_array #(
    .DW(DW),
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(addr_q),
    .wdata(wdata),
    .raddr(addr_q),
    .rdata(rdata)
  );

  // Next-state, counter, memory write and result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    cap     = 1'b0;
    we      = 1'b0;
    wdata   = din_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cap = 1'b1;
          if (WAIT == 0) begin
            state_d = StAcc;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAcc;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StAcc: begin
        case (op_q)
          OP_RD: begin
            dout_d  = rdata;
            state_d = StDone;
          end
          OP_WR: begin
            we      = 1'b1;
            wdata   = din_q;
            dout_d  = din_q;
            state_d = StDone;
          end
          default: begin
            // Old value parks in dout so RMW needs no extra register.
            dout_d  = rdata;
            state_d = StRmw;
          end
        endcase
      end
      StRmw: begin
        wdata   = (op_q == OP_BSET) ? (dout_q | din_q) : (dout_q & ~din_q);
        we      = 1'b1;
        dout_d  = wdata;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter, result and operand capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      dout_q  <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      if (cap) begin
        op_q   <= op;
        addr_q <= addr;
        din_q  <= din;
      end
    end
  end

  assign ack  = (state_q == StDone);
  assign busy = (state_q != StIdle);
  assign dout = dout_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench: three configurations (WAIT=1, WAIT=0, WAIT=15/DW16/AW6).
module tb_data_mem_hs;
  import dmem_pkg::*;

  typedef struct {
    int          dut;
    logic [15:0] dout;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [1:0]  op   [3];
  logic [5:0]  addr [3];
  logic [15:0] din  [3];
  logic [2:0]  ack_v;
  logic [2:0]  busy_v;
  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;
  logic [15:0] dout_w [3];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    dout_w[0] = {8'h00, dout0};
    dout_w[1] = {8'h00, dout1};
    dout_w[2] = dout2;
  end

  data_mem_hs #(.DW(8), .AW(4), .WAIT(1)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .op(op[0]), .addr(addr[0][3:0]),
    .din(din[0][7:0]), .ack(ack_v[0]), .busy(busy_v[0]), .dout(dout0)
  );

  data_mem_hs #(.DW(8), .AW(4), .WAIT(0)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .op(op[1]), .addr(addr[1][3:0]),
    .din(din[1][7:0]), .ack(ack_v[1]), .busy(busy_v[1]), .dout(dout1)
  );

  data_mem_hs #(.DW(16), .AW(6), .WAIT(15)) u2 (
    .clk(clk), .rst(rst), .req(req[2]), .op(op[2]), .addr(addr[2]),
    .din(din[2]), .ack(ack_v[2]), .busy(busy_v[2]), .dout(dout2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pops one expectation per ack and checks dut, data and ack cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          if (ack_v[i]) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL spurious_ack: dut %0d acked at cycle %0d, expected none", i, cyc);
            end else begin
              e = sb.pop_front();
              check("ack_dut", i, e.dut);
              check("dout", {16'h0, dout_w[i]}, {16'h0, e.dout});
              check("ack_cycle", cyc, e.cyc);
            end
          end
        end
      end
    end
  endtask

  // One isolated access; also checks the busy window length.
  task automatic single(input int d, input logic [1:0] o, input logic [5:0] a,
                        input logic [15:0] di, input logic [15:0] ex, input int lat);
    int e0;
    int busy_n;
    @(negedge clk);
    req[d] = 1'b1; op[d] = o; addr[d] = a; din[d] = di;
    e0 = cyc + 1;
    sb.push_back('{d, ex, e0 + lat});
    busy_n = 0;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 0) req[d] = 1'b0;
      if (busy_v[d]) busy_n++;
    end
    check("busy_len", busy_n, lat + 1);
  endtask

  // Two accesses with req held high throughout; optional input scrambling while busy.
  task automatic pair(input int d,
                      input logic [1:0] o1, input logic [5:0] a1, input logic [15:0] d1,
                      input logic [15:0] ex1, input int lat1,
                      input logic [1:0] o2, input logic [5:0] a2, input logic [15:0] d2,
                      input logic [15:0] ex2, input int lat2, input bit scramble);
    int e0;
    int e1;
    @(negedge clk);
    req[d] = 1'b1; op[d] = o1; addr[d] = a1; din[d] = d1;
    e0 = cyc + 1;
    e1 = e0 + lat1 + 2;
    sb.push_back('{d, ex1, e0 + lat1});
    sb.push_back('{d, ex2, e1 + lat2});
    while (cyc < e1 - 1) begin
      @(negedge clk);
      if (cyc == e1 - 1) begin
        op[d] = o2; addr[d] = a2; din[d] = d2;
      end else if (scramble) begin
        op[d] = 2'(cyc); addr[d] = 6'd5; din[d] = 16'h00C3;
      end
    end
    @(negedge clk);
    req[d] = 1'b0;
    while (cyc < e1 + lat2 + 1) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      op[i] = OP_RD; addr[i] = '0; din[i] = '0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", ack_v[i], 0);
      check("rst_busy", busy_v[i], 0);
      check("rst_dout", dout_w[i], 0);
    end
    rst = 1'b0;

    // Reset during a pending write leaves the old word intact.
    single(0, OP_WR, 6'd3, 16'h003C, 16'h003C, 2);
    @(negedge clk);
    req[0] = 1'b1; op[0] = OP_WR; addr[0] = 6'd3; din[0] = 16'h0077;
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ack", ack_v[0], 0);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_dout", dout_w[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    single(0, OP_RD, 6'd3, 16'h0000, 16'h003C, 2);

    // WAIT=1 write/read and bit operations.
    single(0, OP_WR, 6'd5, 16'h00A5, 16'h00A5, 2);
    single(0, OP_RD, 6'd5, 16'h0000, 16'h00A5, 2);
    single(0, OP_WR, 6'd2, 16'h0030, 16'h0030, 2);
    single(0, OP_BSET, 6'd2, 16'h0081, 16'h00B1, 3);
    single(0, OP_BCLR, 6'd2, 16'h0010, 16'h00A1, 3);
    single(0, OP_RD, 6'd2, 16'h0000, 16'h00A1, 2);

    // Input isolation: scrambled buses while busy, req held through DONE.
    pair(0, OP_WR, 6'd7, 16'h005A, 16'h005A, 2, OP_RD, 6'd7, 16'h0000, 16'h005A, 2, 1'b1);
    single(0, OP_RD, 6'd5, 16'h0000, 16'h00A5, 2);

    // WAIT=0: back-to-back at 3-cycle spacing, then an isolated read.
    pair(1, OP_WR, 6'd15, 16'h000F, 16'h000F, 1, OP_RD, 6'd15, 16'h0000, 16'h000F, 1, 1'b0);
    single(1, OP_RD, 6'd15, 16'h0000, 16'h000F, 1);

    // WAIT=15, DW=16, AW=6 at the top address.
    single(2, OP_WR, 6'd63, 16'hBEEF, 16'hBEEF, 16);
    single(2, OP_RD, 6'd63, 16'h0000, 16'hBEEF, 16);

    repeat (4) @(negedge clk);
    while (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_ack: dut %0d got no ack, expected ack at cycle %0d with dout %0h",
               sb[0].dut, sb[0].cyc, sb[0].dout);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
# data_mem_hs

Parametrised data memory for the multi-cycle microcontroller, with a request/acknowledge handshake and programmable wait states. It also provides atomic bit-set and bit-clear read-modify-write operations. It sits between the controller's execute stage and the data storage: the controller issues one request, holds off while `busy` is high, and consumes `dout` on the `ack` pulse. All operands are captured when the request is accepted, so the controller's buses may change during the access.

## Interface
Parameters:
- `DW`, 8: data width in bits.
- `AW`, 4: address width in bits; depth = 2**AW words.
- `WAIT`, 1: extra wait cycles inserted before the array access; legal range 0..15.

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 read, 01 write, 10 bit-set (mask = `din`), 11 bit-clear (mask = `din`).
- `addr`  in  AW  word address.
- `din`  in  DW  write data, or mask for the bit operations.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the block is not in IDLE.
- `dout`  out  DW  registered result: read data, written data, or the new value after a bit-set/clear.

## Operation
- The FSM has five states: IDLE, WAIT, ACC, RMW, DONE.
- IDLE:
  - When `req`=1, capture `op`, `addr` and `din` into internal registers.
  - Go to WAIT with cnt = WAIT-1, or go directly to ACC when WAIT = 0.
- WAIT: decrement cnt; go to ACC when cnt = 0.
- ACC, by captured op:
  - read: `dout` <= mem[addr]; go to DONE.
  - write: mem[addr] <= din and `dout` <= din; go to DONE.
  - bit-set / bit-clear: `dout` <= mem[addr] (old value); go to RMW.
- RMW:
  - bit-set: new = old | mask. bit-clear: new = old & ~mask.
  - mem[addr] <= new and `dout` <= new; go to DONE.
  - The operation is atomic: no other access can interleave between ACC and RMW.
- DONE: `ack`=1; go to IDLE unconditionally. A `req` seen in DONE is not accepted.
- Output decode: `ack` = (state==DONE) and `busy` = (state!=IDLE). Both are decoded from the state register, so they are glitch-free.
- All arithmetic is bitwise and DW wide. The address covers the full depth, so there is no out-of-range case.
- Inputs that change while `busy`=1 are ignored; only the captured copies are used.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - `ack`=0, `busy`=0, `dout`=0.
  - Memory contents are not reset and are undefined until written.
- Call the accepting edge E0:
  - `busy` rises after E0.
  - `ack` is high in the cycle after edge E0+WAIT+1 for read/write, and after edge E0+WAIT+2 for bit-set/clear.
  - `dout` becomes valid in the same cycle `ack` is high and holds until the next ACC or RMW update.
- Minimum request spacing: WAIT+3 cycles for read/write, WAIT+4 cycles for bit-set/clear. This includes the mandatory IDLE cycle after DONE.
- Reset asserted mid-operation:
  - Immediate return to IDLE with outputs at their reset values.
  - A write or RMW whose final memory-write edge has not yet occurred is not performed.
  - Memory words already written keep their values.
- With WAIT=0 the WAIT state is never entered.
- `req` held high continuously is accepted once per pass through IDLE.

## Structure
- Package `dmem_pkg` holds:
  - the op encoding constants (OP_RD, OP_WR, OP_BSET, OP_BCLR);
  - the state typedef or localparams (IDLE, WAIT, ACC, RMW, DONE).
- Sub-module `dmem_array`:
  - parameters `DW` and `AW`;
  - one synchronous write port (`we`, `waddr`, `wdata`) and one combinational read port;
  - no reset on the storage.
- Top level `data_mem_hs` holds the FSM, the capture registers, the wait counter and the `dout` register.

## Test plan
- Reset, WAIT=1: assert `rst` during a pending write to address 3, before its ACC edge. Require `ack`=0, `busy`=0, `dout`=0 immediately; a later read of address 3 returns its previous value.
- WAIT=1: write 0xA5 to address 5, then read address 5. Require `ack` 2 cycles after each acceptance edge, `dout`=0xA5 on both acks, and `busy` high for exactly 3 cycles per access.
- WAIT=0: write 0x0F to address 15, then read it. Require `ack` 1 cycle after acceptance and `dout`=0x0F; back-to-back requests are spaced 3 cycles.
- Bit operations: memory[2]=0x30. Bit-set with mask 0x81 gives `dout`=0xB1. Bit-clear with mask 0x10 gives `dout`=0xA1. A subsequent read of address 2 returns 0xA1. Each bit op's `ack` comes WAIT+2 cycles after acceptance.
- Input isolation: change `addr`, `din` and `op` every cycle while `busy`=1, and hold `req`=1 through DONE. Require only the captured operation to complete, and the next acceptance to occur in the IDLE cycle after DONE.
- WAIT=15, DW=16, AW=6: write 0xBEEF to address 63, then read it. Require `ack` 16 cycles after acceptance and `dout`=0xBEEF.
